// File: rtl/params_pkg.sv
// Shared types and constants for the memory stage of the core.
//   mem_op_e    : memory operation carried down the pipeline
//   mem_state_e : bus transaction FSM states
//   trap_t      : trap record (valid, cause, tval) carried alongside an instruction
//   ex_mem_t    : registered EX/MEM contents consumed by mem_stage
//   mem_wb_t    : next MEM/WB contents produced by mem_stage
package params_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [3:0] LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] LOAD_FAULT       = 4'd5;
  localparam logic [3:0] STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] STORE_FAULT      = 4'd7;

  typedef enum logic [3:0] {
    MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE, WAIT_GNT, WAIT_RSP, DONE, DRAIN
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } trap_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    mem_op_e     mem_op;
    logic [4:0]  rd_addr;
    trap_t       carried_trap;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        rd_we;
    trap_t       carried_trap;
  } mem_wb_t;

  function automatic logic is_load(input mem_op_e op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: purely combinational byte-lane logic for the memory stage.
//   mem_op_i      : operation in MEM
//   offset_i      : address bits [1:0]
//   store_data_i  : register value to store
//   rdata_i       : captured load word from the bus
//   misaligned_o  : halfword on odd address or word not on a 4-byte boundary
//   wstrb_o       : byte enables for stores (0 for non-stores)
//   wdata_o       : store data replicated across all lanes
//   load_data_o   : extracted and sign/zero-extended load result
module lsu_align
  import params_pkg::*;
(
  input  mem_op_e     mem_op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  // Bring the addressed byte/halfword down to bit 0 before extending.
  logic [15:0] lane_data;

  // NOTE: every output gets a default before the case so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    misaligned_o = 1'b0;
    wstrb_o      = 4'b0000;
    wdata_o      = 32'h0;
    load_data_o  = 32'h0;
    lane_data    = 16'(rdata_i >> {offset_i, 3'b000});
    unique case (mem_op_i)
      LB:  load_data_o = {{24{lane_data[7]}}, lane_data[7:0]};
      LBU: load_data_o = {24'h0, lane_data[7:0]};
      LH: begin
        misaligned_o = offset_i[0];
        load_data_o  = {{16{lane_data[15]}}, lane_data[15:0]};
      end
      LHU: begin
        misaligned_o = offset_i[0];
        load_data_o  = {16'h0, lane_data[15:0]};
      end
      LW: begin
        misaligned_o = |offset_i;
        load_data_o  = rdata_i;
      end
      SB: begin
        wstrb_o = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SH: begin
        misaligned_o = offset_i[0];
        wstrb_o      = 4'b0011 << offset_i;
        wdata_o      = {2{store_data_i[15:0]}};
      end
      SW: begin
        misaligned_o = |offset_i;
        wstrb_o      = 4'hF;
        wdata_o      = store_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the core. Runs at most one load/store on the
// data bus per instruction, converts misaligned or faulting accesses into
// traps and builds the next MEM/WB contents.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   mem_pipeline_q      : registered EX/MEM contents
//   mem_flush_i         : kill the instruction in MEM
//   mem_wb_stall_i      : MEM/WB register not accepting
//   mem_stall_o         : hold EX/MEM and everything upstream
//   wb_pipeline_d       : next MEM/WB contents (bubble while stalled/flushed)
//   dmem_req_o/we_o/addr_o/wstrb_o/wdata_o : request channel
//   dmem_gnt_i          : request accepted this cycle
//   dmem_rvalid_i/rdata_i/err_i            : response channel
module mem_stage
  import params_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  ex_mem_t         mem_pipeline_q,
  input  logic            mem_flush_i,
  input  logic            mem_wb_stall_i,
  output logic            mem_stall_o,
  output mem_wb_t         wb_pipeline_d,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_wstrb_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_err_i
);

  mem_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        ld, st, misaligned, need_access, bus_stall, access_err;
  logic [31:0] addr, wdata, load_data;
  logic [3:0]  wstrb;

  assign addr = mem_pipeline_q.alu_result;
  assign ld   = is_load(mem_pipeline_q.mem_op);
  assign st   = is_store(mem_pipeline_q.mem_op);

  lsu_align u_align (
    .mem_op_i     (mem_pipeline_q.mem_op),
    .offset_i     (addr[1:0]),
    .store_data_i (mem_pipeline_q.store_data),
    .rdata_i      (rdata_q),
    .misaligned_o (misaligned),
    .wstrb_o      (wstrb),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  assign need_access = mem_pipeline_q.valid && (ld || st) &&
                       !mem_pipeline_q.carried_trap.valid &&
                       !misaligned && !mem_flush_i;

  // Request fields come straight from EX/MEM, which is held by mem_stall_o
  // while the request is pending, so they stay stable until the grant.
  assign dmem_we_o    = st;
  assign dmem_addr_o  = {addr[31:2], 2'b00};
  assign dmem_wstrb_o = wstrb;
  assign dmem_wdata_o = wdata;

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    dmem_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req_o = need_access;
        if (need_access && dmem_gnt_i) state_d = WAIT_RSP;
        else if (need_access)          state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        // Nothing has been granted yet, so a flush can simply withdraw.
        dmem_req_o = !mem_flush_i;
        if (mem_flush_i)     state_d = IDLE;
        else if (dmem_gnt_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          if (mem_flush_i) begin
            state_d = IDLE;
          end else begin
            rdata_d = dmem_rdata_i;
            err_d   = dmem_err_i;
            state_d = DONE;
          end
        end else if (mem_flush_i) begin
          // The granted access still owes a response; swallow it first.
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (!mem_wb_stall_i || mem_flush_i) state_d = IDLE;
      end
      DRAIN: begin
        if (dmem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_stall = (state_q == IDLE && need_access) ||
                     (state_q inside {WAIT_GNT, WAIT_RSP, DRAIN});
  assign mem_stall_o = bus_stall || mem_wb_stall_i;

  // Captured error only belongs to the instruction that finished its access.
  assign access_err = (state_q == DONE) && err_q;

  always_comb begin
    wb_pipeline_d      = '0;
    wb_pipeline_d.insn = NOP_INSN;
    if (mem_pipeline_q.valid && !bus_stall && !mem_flush_i) begin
      wb_pipeline_d.valid   = 1'b1;
      wb_pipeline_d.insn    = mem_pipeline_q.insn;
      wb_pipeline_d.pc      = mem_pipeline_q.pc;
      wb_pipeline_d.rd_addr = mem_pipeline_q.rd_addr;
      if (mem_pipeline_q.carried_trap.valid) begin
        wb_pipeline_d.carried_trap = mem_pipeline_q.carried_trap;
      end else if (misaligned) begin
        wb_pipeline_d.carried_trap = '{valid: 1'b1,
                                       cause: st ? STORE_MISALIGNED : LOAD_MISALIGNED,
                                       tval:  addr};
      end else if (access_err) begin
        wb_pipeline_d.carried_trap = '{valid: 1'b1,
                                       cause: st ? STORE_FAULT : LOAD_FAULT,
                                       tval:  addr};
      end else if (ld) begin
        wb_pipeline_d.rd_we    = 1'b1;
        wb_pipeline_d.rd_wdata = load_data;
      end else if (!st) begin
        wb_pipeline_d.rd_we    = 1'b1;
        wb_pipeline_d.rd_wdata = addr;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: reset, a table of single-cycle vectors,
// directed multi-cycle sequences (flush/drain, withheld grant, faults) and
// randomized transactions checked against a byte-level reference model.
module tb_mem_stage;
  import params_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  ex_mem_t     mem_pipeline_q;
  logic        mem_flush_i, mem_wb_stall_i, mem_stall_o;
  mem_wb_t     wb_pipeline_d;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mem_pipeline_q (mem_pipeline_q),
    .mem_flush_i    (mem_flush_i),
    .mem_wb_stall_i (mem_wb_stall_i),
    .mem_stall_o    (mem_stall_o),
    .wb_pipeline_d  (wb_pipeline_d),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wstrb_o   (dmem_wstrb_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .dmem_err_i     (dmem_err_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled later in the cycle.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pipe(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata);
    mem_pipeline_q              = '0;
    mem_pipeline_q.valid        = 1'b1;
    mem_pipeline_q.insn         = 32'h0000_2003;
    mem_pipeline_q.pc           = 32'h0000_1000;
    mem_pipeline_q.alu_result   = addr;
    mem_pipeline_q.store_data   = sdata;
    mem_pipeline_q.mem_op       = op;
    mem_pipeline_q.rd_addr      = 5'd7;
  endtask

  task automatic idle_bus();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = 32'h0;
    mem_flush_i = 1'b0; mem_wb_stall_i = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    mem_op_e     op;
    logic [31:0] addr, sdata, rdata;
    logic        err, ctrap;
    logic [3:0]  ccause;
    int          gnt_delay, rsp_delay, wb_stall;
  } txn_t;

  typedef struct {
    logic        access, we;
    logic [3:0]  wstrb;
    logic [31:0] waddr, wdata;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic        rd_we;
    logic [31:0] rd_wdata;
    int          stall_cycles, req_cycles;
  } exp_t;

  typedef exp_t obs_t;

  function automatic exp_t model(input txn_t t);
    exp_t e;
    int size, off;
    bit ld, st;
    longint unsigned v;
    e = '{default: 0};
    ld = t.op inside {LB, LH, LW, LBU, LHU};
    st = t.op inside {SB, SH, SW};
    off = int'(t.addr % 4);
    case (t.op)
      LB, LBU, SB: size = 1;
      LH, LHU, SH: size = 2;
      LW, SW:      size = 4;
      default:     size = 0;
    endcase
    if (t.ctrap) begin
      e.trap = 1'b1; e.cause = t.ccause; e.tval = t.sdata;
    end else if (size == 0) begin
      e.rd_we = 1'b1; e.rd_wdata = t.addr;
    end else if (off % size != 0) begin
      e.trap = 1'b1; e.cause = st ? 4'd6 : 4'd4; e.tval = t.addr;
    end else begin
      e.access = 1'b1;
      e.we = st;
      e.waddr = t.addr - 32'(off);
      e.stall_cycles = t.gnt_delay + t.rsp_delay + 1;
      e.req_cycles = t.gnt_delay + 1;
      if (st) begin
        for (int k = 0; k < 4; k++) begin
          e.wstrb[k] = (k >= off) && (k < off + size);
          e.wdata[8*k +: 8] = t.sdata[8*(k % size) +: 8];
        end
      end
      if (t.err) begin
        e.trap = 1'b1; e.cause = st ? 4'd7 : 4'd5; e.tval = t.addr;
      end else if (ld) begin
        v = longint'(t.rdata >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
        if ((t.op == LB || t.op == LH) && v[8*size-1]) v = v - (64'd1 << (8 * size));
        e.rd_we = 1'b1;
        e.rd_wdata = v[31:0];
      end
    end
    return e;
  endfunction

  // Runs one instruction through MEM acting as the bus slave and the WB stage.
  task automatic exec(input txn_t t, output obs_t o);
    exp_t e;
    int cyc, gcyc, wbs_left;
    bit done, rsp_sent;
    logic [31:0] pc;
    e = model(t);
    o = '{default: 0};
    cyc = 0; gcyc = -1; wbs_left = t.wb_stall; done = 1'b0; rsp_sent = 1'b0;
    pc = $urandom & 32'hFFFF_FFFC;
    set_pipe(t.op, t.addr, t.sdata);
    mem_pipeline_q.pc = pc;
    mem_pipeline_q.carried_trap = '{valid: t.ctrap, cause: t.ccause, tval: t.sdata};
    while (!done && cyc < 64) begin
      idle_bus();
      dmem_rdata_i = $urandom;
      if (gcyc >= 0 && !rsp_sent && cyc == gcyc + t.rsp_delay) begin
        dmem_rvalid_i = 1'b1; dmem_rdata_i = t.rdata; dmem_err_i = t.err; rsp_sent = 1'b1;
      end
      #1;
      if (dmem_req_o) begin
        o.req_cycles++;
        check("bus_addr", dmem_addr_o, e.waddr);
        check("bus_we", 32'(dmem_we_o), 32'(e.we));
        if (e.we) begin
          check("bus_wstrb", 32'(dmem_wstrb_o), 32'(e.wstrb));
          check("bus_wdata", dmem_wdata_o, e.wdata);
        end
        if (gcyc < 0 && o.req_cycles == t.gnt_delay + 1) begin
          dmem_gnt_i = 1'b1; gcyc = cyc;
        end
      end
      if (wb_pipeline_d.valid && wbs_left > 0) begin
        mem_wb_stall_i = 1'b1; wbs_left--;
      end
      #1;
      if (!wb_pipeline_d.valid) begin
        if (mem_stall_o) o.stall_cycles++;
        check("bubble_insn", wb_pipeline_d.insn, NOP_INSN);
      end else if (mem_wb_stall_i) begin
        check("wb_stall_holds", 32'(mem_stall_o), 32'd1);
      end else begin
        check("advance_no_stall", 32'(mem_stall_o), 32'd0);
        check("wb_pc", wb_pipeline_d.pc, pc);
        o.trap = wb_pipeline_d.carried_trap.valid;
        o.cause = wb_pipeline_d.carried_trap.cause;
        o.tval = wb_pipeline_d.carried_trap.tval;
        o.rd_we = wb_pipeline_d.rd_we;
        o.rd_wdata = wb_pipeline_d.rd_wdata;
        done = 1'b1;
      end
      next_cycle();
      cyc++;
    end
    idle_bus();
    check("txn_completed", 32'(done), 32'd1);
    check("trap_valid", 32'(o.trap), 32'(e.trap));
    if (e.trap) begin
      check("trap_cause", 32'(o.cause), 32'(e.cause));
      check("trap_tval", o.tval, e.tval);
    end
    check("rd_we", 32'(o.rd_we), 32'(e.rd_we));
    if (e.rd_we) check("rd_wdata", o.rd_wdata, e.rd_wdata);
    check("bus_stall_cycles", 32'(o.stall_cycles), 32'(e.stall_cycles));
    check("req_cycles", 32'(o.req_cycles), 32'(e.req_cycles));
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    mem_op_e     op;
    logic [31:0] addr, sdata;
    logic        ctrap, req, we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stall, valid, trap;
    logic [3:0]  cause;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    txn_t t;
    obs_t o;

    vecs[0] = '{SH,       32'h102, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
    vecs[1] = '{SB,       32'h101, 32'h000000A5, 1'b0, 1'b1, 1'b1, 4'b0010, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
    vecs[2] = '{SW,       32'h200, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
    vecs[3] = '{SB,       32'h103, 32'h00000077, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h77777777, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
    vecs[4] = '{LW,       32'h101, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 4'd4, 32'h0};
    vecs[5] = '{SH,       32'h103, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 4'd6, 32'h0};
    vecs[6] = '{LHU,      32'h201, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 4'd4, 32'h0};
    vecs[7] = '{SW,       32'h202, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 4'd6, 32'h0};
    vecs[8] = '{MEM_NONE, 32'h55,  32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 4'd0, 32'h55};
    vecs[9] = '{LW,       32'h100, 32'h0,        1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 4'd2, 32'h0};

    // Reset
    rst_i = 1'b1;
    mem_pipeline_q = '0;
    idle_bus();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("reset_req", 32'(dmem_req_o), 32'd0);
    check("reset_stall", 32'(mem_stall_o), 32'd0);
    check("reset_wb_valid", 32'(wb_pipeline_d.valid), 32'd0);
    check("reset_wb_insn", wb_pipeline_d.insn, NOP_INSN);
    next_cycle();

    // Table vectors: observe the first cycle, then flush back to IDLE.
    foreach (vecs[i]) begin
      set_pipe(vecs[i].op, vecs[i].addr, vecs[i].sdata);
      mem_pipeline_q.carried_trap = '{valid: vecs[i].ctrap, cause: 4'd2, tval: 32'hBEEF};
      #1;
      check($sformatf("vec%0d_req", i), 32'(dmem_req_o), 32'(vecs[i].req));
      if (vecs[i].req) check($sformatf("vec%0d_we", i), 32'(dmem_we_o), 32'(vecs[i].we));
      if (vecs[i].req && vecs[i].we) begin
        check($sformatf("vec%0d_addr", i), dmem_addr_o, vecs[i].addr & 32'hFFFF_FFFC);
        check($sformatf("vec%0d_wstrb", i), 32'(dmem_wstrb_o), 32'(vecs[i].wstrb));
        check($sformatf("vec%0d_wdata", i), dmem_wdata_o, vecs[i].wdata);
      end
      check($sformatf("vec%0d_stall", i), 32'(mem_stall_o), 32'(vecs[i].stall));
      check($sformatf("vec%0d_valid", i), 32'(wb_pipeline_d.valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_trap", i), 32'(wb_pipeline_d.carried_trap.valid), 32'(vecs[i].trap));
        if (vecs[i].trap) check($sformatf("vec%0d_cause", i), 32'(wb_pipeline_d.carried_trap.cause), 32'(vecs[i].cause));
        else check($sformatf("vec%0d_rd", i), wb_pipeline_d.rd_wdata, vecs[i].rd);
      end
      next_cycle();
      mem_flush_i = 1'b1;
      #1;
      check($sformatf("vec%0d_flush_req", i), 32'(dmem_req_o), 32'd0);
      check($sformatf("vec%0d_flush_valid", i), 32'(wb_pipeline_d.valid), 32'd0);
      next_cycle();
      mem_flush_i = 1'b0;
    end
    mem_pipeline_q.valid = 1'b0;
    next_cycle();

    // Directed: LW 0x100, minimum latency
    t = '{op: LW, addr: 32'h100, sdata: 32'h0, rdata: 32'hDEADBEEF, err: 1'b0, ctrap: 1'b0,
          ccause: 4'd0, gnt_delay: 0, rsp_delay: 1, wb_stall: 0};
    exec(t, o);
    check("lw_stall_2", 32'(o.stall_cycles), 32'd2);
    check("lw_data", o.rd_wdata, 32'hDEADBEEF);

    // Directed: LB / LBU at 0x203
    t.op = LB; t.addr = 32'h203; t.rdata = 32'h80FF_0000;
    exec(t, o);
    check("lb_sext", o.rd_wdata, 32'hFFFFFF80);
    t.op = LBU;
    exec(t, o);
    check("lbu_zext", o.rd_wdata, 32'h00000080);

    // Directed: misaligned LW, no bus activity
    t.op = LW; t.addr = 32'h101;
    exec(t, o);
    check("mis_cause", 32'(o.cause), 32'd4);
    check("mis_tval", o.tval, 32'h101);
    check("mis_no_req", 32'(o.req_cycles), 32'd0);
    check("mis_no_stall", 32'(o.stall_cycles), 32'd0);

    // Directed: grant withheld 4 cycles, store faults
    t = '{op: SW, addr: 32'h340, sdata: 32'h13579BDF, rdata: 32'h0, err: 1'b1, ctrap: 1'b0,
          ccause: 4'd0, gnt_delay: 4, rsp_delay: 2, wb_stall: 1};
    exec(t, o);
    check("sw_err_cause", 32'(o.cause), 32'd7);
    check("sw_err_rd_we", 32'(o.rd_we), 32'd0);
    check("sw_req_cycles", 32'(o.req_cycles), 32'd5);

    // Directed: flush in WAIT_RSP -> DRAIN, late response discarded
    set_pipe(LW, 32'h300, 32'h0);
    #1;
    check("drain_first_req", 32'(dmem_req_o), 32'd1);
    dmem_gnt_i = 1'b1;
    next_cycle();
    dmem_gnt_i = 1'b0;
    mem_flush_i = 1'b1;
    #1;
    check("drain_flush_stall", 32'(mem_stall_o), 32'd1);
    check("drain_flush_valid", 32'(wb_pipeline_d.valid), 32'd0);
    next_cycle();
    mem_flush_i = 1'b0;
    set_pipe(LW, 32'h400, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("drain_no_req", 32'(dmem_req_o), 32'd0);
      check("drain_stall", 32'(mem_stall_o), 32'd1);
      next_cycle();
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hBAD0BAD0;
    #1;
    check("drain_rsp_no_req", 32'(dmem_req_o), 32'd0);
    check("drain_rsp_stall", 32'(mem_stall_o), 32'd1);
    check("drain_rsp_valid", 32'(wb_pipeline_d.valid), 32'd0);
    next_cycle();
    dmem_rvalid_i = 1'b0;
    #1;
    check("post_drain_req", 32'(dmem_req_o), 32'd1);
    check("post_drain_addr", dmem_addr_o, 32'h400);
    dmem_gnt_i = 1'b1;
    next_cycle();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h11223344;
    next_cycle();
    dmem_rvalid_i = 1'b0;
    #1;
    check("post_drain_valid", 32'(wb_pipeline_d.valid), 32'd1);
    check("post_drain_stall", 32'(mem_stall_o), 32'd0);
    check("post_drain_data", wb_pipeline_d.rd_wdata, 32'h11223344);
    next_cycle();

    // Directed: flush together with rvalid returns straight to IDLE
    set_pipe(LW, 32'h500, 32'h0);
    dmem_gnt_i = 1'b1;
    next_cycle();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    mem_flush_i = 1'b1;
    next_cycle();
    idle_bus();
    set_pipe(LW, 32'h600, 32'h0);
    #1;
    check("flush_rsp_idle_req", 32'(dmem_req_o), 32'd1);
    next_cycle();
    mem_flush_i = 1'b1;
    next_cycle();
    mem_flush_i = 1'b0;

    // Reset in WAIT_GNT returns to IDLE
    set_pipe(SW, 32'h700, 32'h1);
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    mem_pipeline_q.valid = 1'b0;
    #1;
    check("midrst_req", 32'(dmem_req_o), 32'd0);
    check("midrst_stall", 32'(mem_stall_o), 32'd0);
    next_cycle();

    // Randomized transactions
    for (int n = 0; n < 200; n++) begin
      t.op        = mem_op_e'($urandom_range(0, 8));
      t.addr      = $urandom & 32'h0000_FFFF;
      t.sdata     = $urandom;
      t.rdata     = $urandom;
      t.err       = ($urandom_range(0, 7) == 0);
      t.ctrap     = ($urandom_range(0, 9) == 0);
      t.ccause    = 4'($urandom_range(0, 3));
      t.gnt_delay = $urandom_range(0, 3);
      t.rsp_delay = $urandom_range(1, 3);
      t.wb_stall  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      exec(t, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the core. Consumes the registered EX/MEM pipeline struct and runs one load/store transaction on the data-memory bus.
- Handles store byte-lane alignment, load extraction and extension, and misaligned or faulting accesses (converted to traps).
- Produces the mem_wb_t struct feeding the MEM/WB register, and stalls upstream while a bus access is outstanding.

Parameters:
- XLEN, 32, data/address width; only 32 supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mem_pipeline_q  in  ex_mem_t  registered EX/MEM contents: valid, insn, pc, alu_result (address), store_data, mem_op, rd_addr, carried_trap
- mem_flush_i  in  1  kill instruction in MEM (trap/redirect from WB)
- mem_wb_stall_i  in  1  MEM/WB register not accepting
- mem_stall_o  out  1  hold EX/MEM and everything upstream
- wb_pipeline_d  out  mem_wb_t  next MEM/WB contents
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wstrb_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  response/ack
- dmem_rdata_i  in  32  load data
- dmem_err_i  in  1  access fault, qualified by rvalid

Behaviour:
- Reset: state IDLE, captured rdata/err = 0, dmem_req_o = 0, mem_stall_o = 0, wb_pipeline_d.valid = 0.
- need_access = valid && mem_op != MEM_NONE && !carried_trap.valid && !misaligned && !mem_flush_i.
- misaligned: halfword with addr[0] set, or word with addr[1:0] != 0.
  - Load raises cause 4, store cause 6; tval = address.
  - No bus access; passes through with no stall.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP, DONE, DRAIN.
  - IDLE: dmem_req_o = need_access. gnt → WAIT_RSP; else if need_access → WAIT_GNT.
  - WAIT_GNT: req held high with stable addr/we/wstrb/wdata until gnt → WAIT_RSP. flush → IDLE, req drops the same cycle (no grant yet).
  - WAIT_RSP: on rvalid, capture rdata/err → DONE. flush without rvalid → DRAIN; flush with rvalid → IDLE, data discarded.
  - DONE: no request. If !mem_wb_stall_i or flush → IDLE.
  - DRAIN: req = 0. Wait for rvalid, discard → IDLE.
- mem_stall_o = need_access in IDLE, or state ∈ {WAIT_GNT, WAIT_RSP, DRAIN}, or mem_wb_stall_i.
- Minimum access latency: gnt in cycle 0, rvalid in cycle 1, DONE in cycle 2.
  - Stall is high in cycles 0–1.
  - Instruction advances at end of cycle 2.
- wb_pipeline_d:
  - Valid only when not stalled by the bus FSM and not flushed.
  - While stalled or flushed it is a bubble: all-zero, insn = 32'h00000013.
- Loads: byte/half selected by addr[1:0] from the captured rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
- Stores:
  - SB: wstrb = 4'b0001 << addr[1:0], wdata = {4{b}}.
  - SH: wstrb = 4'b0011 << addr[1:0], wdata = {2{h}}.
  - SW: wstrb = 4'hF.
- Captured err: load → trap cause 5, store → cause 7; tval = address; rd write suppressed.
- Carried trap from upstream passes unchanged; no access is made.
- Non-memory instructions pass alu_result as the rd result with zero stall.
- Only one outstanding transaction. A new request is never issued in DONE or DRAIN.

Decomposition:
- params_pkg gains:
  - mem_op_e: MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
  - mem_state_e
  - trap cause constants: LOAD_MISALIGNED=4, LOAD_FAULT=5, STORE_MISALIGNED=6, STORE_FAULT=7
  - mem_wb_t: valid, insn, pc, rd_addr, rd_wdata, rd_we, carried_trap
- One combinational sub-module, lsu_align: misalign detect, wstrb/wdata generation, load extract/extend. mem_stage holds the FSM and capture registers.

Test Plan:
- LW addr 0x100, gnt in cycle 0, rvalid in cycle 1 with rdata 0xDEADBEEF → stall high 2 cycles; wb_pipeline_d valid with rd_wdata 0xDEADBEEF in cycle 2.
- LB addr 0x203, rdata 0x80FF_0000 → rd_wdata 0xFFFFFF80; LBU same access → 0x00000080.
- SH addr 0x102, data 0x1234ABCD → wstrb 4'b1100, wdata 0xABCDABCD, we = 1.
- LW addr 0x101 → no dmem_req_o, zero stall, trap cause 4 with tval 0x101.
- Flush while in WAIT_RSP:
  - FSM enters DRAIN with stall high and no new req, even when a valid load follows.
  - rvalid arrives 3 cycles later and is discarded.
  - Next load is then issued.
- gnt withheld 4 cycles → req/addr/wstrb stable all 4 cycles; store rvalid with err = 1 → trap cause 7, rd_we = 0.
